data_mem: RTL
=============

# data_mem

Parametrised byte-addressable data memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 32-bit, 256-byte, combinational-read memory with a request/response interface and byte, halfword and word accesses. Loads can be sign- or zero-extended, the access latency is programmable, and access errors are flagged. It sits between the CPU load/store unit and the byte storage array.

## Interface
- DEPTH, 256, storage size in bytes; power of two, ≥ 8
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15
- INIT_FILE, "", hex file loaded into storage with $readmemh at elaboration when non-empty
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data; only the low 8/16/32 bits are used according to req_size
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access error

## Operation
- Byte order is little-endian: byte k of an access is stored at address addr+k.
- The effective address is req_addr mod DEPTH; the upper address bits are ignored.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted (handshake). If LATENCY==1, go to RESP; otherwise go to WAIT.
  - WAIT: req_ready=0. A counter loads LATENCY-2 on entry and decrements each cycle. When the counter reaches 0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_ready, go to IDLE.
- At the acceptance edge:
  - Stores write the selected bytes.
  - Loads capture the selected bytes and extend them to 32 bits, and the result is registered.
  - The registered response does not change until the next acceptance.
- Errors:
  - req_size==11 is an error.
  - An error access does no write, returns rsp_rdata=0, and sets rsp_err=1.
  - An error still takes the normal LATENCY path.
- Storage contents are not reset. Only the FSM, the counter and the response registers are reset.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- If a request is accepted on edge T, rsp_valid rises after edge T+LATENCY-1 and is visible in cycle T+LATENCY.
- rsp_valid, rsp_rdata and rsp_err stay stable while rsp_ready=0.
- If rsp_ready=1 in the first RESP cycle, the next request can be accepted no earlier than one cycle later, because req_ready is combinational from state == IDLE.
- The new request can be accepted in the same cycle as... no: req_ready only rises after the FSM returns to IDLE.
- Throughput is one access per LATENCY+1 cycles.
- Store then load to the same address: the load observes the stored data, because the store commits at its own acceptance edge.
- Reset asserted mid-operation (WAIT or RESP):
  - FSM goes immediately to IDLE and the pending response is discarded.
  - A store accepted before reset stays committed.

## Configuration
- DATA_MEM_ALIGN_CHECK_EN defined:
  - A halfword at an odd address, or a word with addr[1:0]≠00, is an error (rsp_err=1, no write, rdata=0).
- DATA_MEM_ALIGN_CHECK_EN undefined:
  - Misaligned accesses are performed byte-wise.
  - Byte addresses wrap modulo DEPTH, e.g. a word at DEPTH-2 uses bytes DEPTH-2, DEPTH-1, 0, 1.
  - rsp_err is only set for size 11.

## Structure
- Package data_mem_pkg:
  - size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state enum IDLE/WAIT/RESP
  - function returning the byte count for a size
- Sub-module data_mem_ext: combinational load extender (size, unsigned, 32-bit raw in → 32-bit extended out). It is reused by the CPU writeback path.

## Test plan
- Reset, then LATENCY=1. Store word 0xDEADBEEF @0x10, then load word @0x10 → rsp_rdata=0xDEADBEEF. Load byte @0x13 signed → 0xFFFFFFDE. Load byte @0x13 unsigned → 0x000000DE.
- Store byte 0x7F @0x21 over a word that holds 0x11223344 @0x20. Load word @0x20 → 0x11227F44. Load half @0x20 signed → 0x00007F44.
- LATENCY=4 with rsp_ready held 0 for 3 cycles after rsp_valid:
  - rsp_valid first seen exactly 4 cycles after acceptance.
  - Data stable throughout.
  - req_ready=0 until one cycle after rsp_ready=1.
- Size=11 store @0x30 → rsp_err=1, rdata=0. Following load word @0x30 returns the prior contents unchanged.
- Align check:
  - With DATA_MEM_ALIGN_CHECK_EN: word load @0x02 → rsp_err=1.
  - Without it, DEPTH=256: store word 0xAABBCCDD @0xFE, then load bytes @0xFE, @0xFF, @0x00, @0x01 → 0xDD, 0xCC, 0xBB, 0xAA.
- Assert rst_n low during WAIT of an accepted store (LATENCY=3):
  - rsp_valid never rises.
  - req_ready=1 right after reset.
  - Reading the address returns the stored value.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Purpose  : Shared types for the data memory. Contains the access-size codes,
//            the request/response FSM states and a byte-count helper.
// Revision : 1.0  initial release
// ============================================================================
package data_mem_pkg;

  // Access size encoding on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Request/response sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (0 for reserved)
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ext.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ext
// Purpose  : Combinational load extender. Takes the raw little-endian bytes of
//            a load and sign- or zero-extends the selected byte/halfword to
//            32 bits. Also used by the CPU writeback path.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_ext
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Select the low bytes for the size and fill the upper bits
  always_comb begin
    ext = 32'd0;
    case (size)
      SZ_BYTE: ext = uns ? {24'd0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: ext = uns ? {16'd0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      SZ_WORD: ext = raw;
      default: ext = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Purpose  : Byte-addressable data memory with a valid/ready request and
//            response interface, byte/halfword/word little-endian accesses,
//            sign/zero-extended loads and a programmable response latency.
//            Optional build macro DATA_MEM_ALIGN_CHECK_EN turns misaligned
//            halfword/word accesses into errors; without it they are done
//            byte-wise with addresses wrapping modulo DEPTH.
// Revision : 1.0  initial release
// ============================================================================
module data_mem
  import data_mem_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  // WAIT holds LATENCY-1 cycles: counter starts at LATENCY-2 and exits at 0
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [7:0]    mem [DEPTH];
  state_t        state;
  logic [3:0]    cnt;
  logic          accept;
  logic          misaligned;
  logic          access_err;
  logic [2:0]    nbytes;
  logic [AW-1:0] byte_addr [4];
  logic [31:0]   raw_data;
  logic [31:0]   ext_data;
  logic          unused_addr_bits;

  // Upper address bits select nothing: the address wraps modulo DEPTH
  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign nbytes    = size_bytes(req_size);

  // Per-lane byte addresses wrap inside the array, giving byte-wise
  // misaligned accesses that roll over from DEPTH-1 to 0
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign byte_addr[g]      = req_addr[AW-1:0] + AW'(g);
    assign raw_data[8*g +: 8] = mem[byte_addr[g]];
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign access_err = (req_size == SZ_RSVD) || misaligned;

  data_mem_ext u_ext (
    .size (req_size),
    .uns  (req_unsigned),
    .raw  (raw_data),
    .ext  (ext_data)
  );

  // Stores commit their selected bytes at the acceptance edge; not reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !access_err) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem[byte_addr[k]] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Request/response sequencing with registered response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rdata <= (req_we || access_err) ? 32'd0 : ext_data;
            rsp_err   <= access_err;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
